// File: rtl/de0_nano_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package de0_nano_multi_timer_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_SNAP     = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;
    localparam logic [2:0] REG_IRQ_PEND = 3'd5;

    localparam int ST_TO     = 0;
    localparam int ST_RUN    = 1;
    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

endpackage

// File: rtl/de0_nano_timer_channel.sv
// One timer channel: register file, clock prescaler, down-counter and interrupt.
module de0_nano_timer_channel
    import de0_nano_multi_timer_pkg::*;
#(
    parameter int          CNT_W          = 32,
    parameter int          PRESC_W        = 16,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h0001_387F
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr,
    input  logic [2:0]        reg_sel,
    input  logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] irq_pend,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    localparam logic [CNT_W-1:0] PERIOD_INIT = DEFAULT_PERIOD[CNT_W-1:0];

    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   snap;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] presc_cnt;
    logic               ito;
    logic               cont;
    logic               run;
    logic               to;

    logic wr_status, wr_control, wr_period, wr_snap, wr_prescale;
    logic start, stop, tick, timeout;
    logic unused_wd;

    assign unused_wd = ^writedata;

    always_comb begin
        wr_status   = wr && (reg_sel == REG_STATUS);
        wr_control  = wr && (reg_sel == REG_CONTROL);
        wr_period   = wr && (reg_sel == REG_PERIOD);
        wr_snap     = wr && (reg_sel == REG_SNAP);
        wr_prescale = wr && (reg_sel == REG_PRESCALE);
        start       = wr_control && writedata[CTL_START];
        stop        = wr_control && writedata[CTL_STOP];
        // A STOP strobe freezes the counter at its value in the write cycle.
        tick        = run && (presc_cnt == '0) && !stop;
        timeout     = tick && (counter == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            counter   <= PERIOD_INIT;
            period    <= PERIOD_INIT;
            snap      <= '0;
            prescale  <= '0;
            presc_cnt <= '0;
            ito       <= 1'b0;
            cont      <= 1'b0;
            run       <= 1'b0;
            to        <= 1'b0;
        end else begin
            if (wr_control) begin
                ito  <= writedata[CTL_ITO];
                cont <= writedata[CTL_CONT];
            end
            if (wr_prescale) prescale <= writedata[PRESC_W-1:0];
            if (wr_snap)     snap     <= counter;
            // Set beats clear so a timeout landing on a STATUS write is kept.
            to <= (to && !wr_status) || timeout;

            if (wr_period) begin
                period    <= writedata[CNT_W-1:0];
                counter   <= writedata[CNT_W-1:0];
                presc_cnt <= '0;
                run       <= 1'b0;
            end else begin
                if (tick) counter <= timeout ? period : counter - 1'b1;

                if (stop)                    run <= 1'b0;
                else if (start)              run <= 1'b1;
                else if (timeout && !cont)   run <= 1'b0;

                if (start && !stop)          presc_cnt <= '0;
                else if (tick)               presc_cnt <= prescale;
                else if (run && !stop)       presc_cnt <= presc_cnt - 1'b1;
            end
        end
    end

    assign irq = to && ito;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_STATUS:   rdata = DATA_W'({run, to});
            REG_CONTROL:  rdata = DATA_W'({cont, ito});
            REG_PERIOD:   rdata = DATA_W'(period);
            REG_SNAP:     rdata = DATA_W'(snap);
            REG_PRESCALE: rdata = DATA_W'(prescale);
            REG_IRQ_PEND: rdata = irq_pend;
            default:      rdata = '0;
        endcase
    end

endmodule

// File: rtl/de0_nano_multi_timer.sv
// Avalon-MM multi-channel interval timer: address decode, channel array, read mux.
module de0_nano_multi_timer
    import de0_nano_multi_timer_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 32,
    parameter int          PRESC_W        = 16,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h0001_387F
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [$clog2(NUM_CH)+2:0]  address,
    input  logic                       chipselect,
    input  logic                       write_n,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    output logic [NUM_CH-1:0]          irq
);

    localparam int AW = $clog2(NUM_CH) + 3;

    logic [3:0]        ch_idx;
    logic [2:0]        reg_sel;
    logic              wr;
    logic [DATA_W-1:0] irq_word;
    logic [DATA_W-1:0] rd_next;
    logic [DATA_W-1:0] rd_ch [NUM_CH];

    assign reg_sel  = address[2:0];
    assign wr       = chipselect && !write_n;
    assign irq_word = DATA_W'(irq);

    // A single-channel build has no channel field in the address.
    if (AW > 3) begin : g_idx
        assign ch_idx = 4'(address[AW-1:3]);
    end else begin : g_no_idx
        assign ch_idx = '0;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        de0_nano_timer_channel #(
            .CNT_W          (CNT_W),
            .PRESC_W        (PRESC_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_channel (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr        (wr && (ch_idx == 4'(i))),
            .reg_sel   (reg_sel),
            .writedata (writedata),
            .irq_pend  (irq_word),
            .rdata     (rd_ch[i]),
            .irq       (irq[i])
        );
    end

    // Channel indices with no instance fall through to zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == 4'(i)) rd_next = rd_ch[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end

endmodule
